dfx_seq_ctrl: RTL and testbench

Bank0 sequencer controller, directly downstream of the AXI-Lite write slave: consumes its bank0 control/endCnt write strobes, walks bank1 slot table entries 0..endCnt, issues one DMA job per slot, and writes per-slot status and cycle profile back to bank1. It owns the run state machine; the slot table storage and the DMA engine are separate blocks.

---
 rtl/dfx_seq_pkg.sv | 33 +++
 rtl/dfx_seq_prof_cnt.sv | 39 +++
 rtl/dfx_seq_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_dfx_seq_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dfx_seq_pkg.sv
// rtl/dfx_seq_pkg.sv - shared types and constants for the bank0 sequencer controller
//
// Purpose: FSM state encoding, bank1 slot status codes and the bit positions
//          of the bank0 control word and global status word.
// Ports:   none (package).

package dfx_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_ISSUE = 3'd2,
      ST_WAIT  = 3'd3,
      ST_WB    = 3'd4
   } seq_state_t;

   // Slot status codes written back to bank1.
   localparam logic [1:0] SLOT_IDLE = 2'b00;
   localparam logic [1:0] SLOT_RUN  = 2'b01;
   localparam logic [1:0] SLOT_OK   = 2'b10;
   localparam logic [1:0] SLOT_ERR  = 2'b11;

   // Control word bit indices.
   localparam int CTRL_START = 0;
   localparam int CTRL_ABORT = 1;
   localparam int CTRL_CLEAR = 2;

   // Global status word bit indices.
   localparam int STAT_BUSY    = 0;
   localparam int STAT_DONE    = 1;
   localparam int STAT_ABORTED = 2;

endpackage

// File: rtl/dfx_seq_prof_cnt.sv
// rtl/dfx_seq_prof_cnt.sv - clear/enable saturating cycle counter for slot profiling
//
// Purpose: counts cycles while en is high, sticks at all-ones, cleared by clr.
//          Only instantiated when DFX_SEQ_PROFILE_EN is defined.
// Ports:
//   clk, reset     clock, asynchronous active-low reset
//   clr            synchronous clear (wins over en)
//   en             count enable
//   count_next     value the counter takes at the next edge when en is high

module dfx_seq_prof_cnt
#(
   parameter int WIDTH = 32
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   output logic [WIDTH-1:0] count_next
);

   logic [WIDTH-1:0] count_q;

   // Exposing the incremented value lets the caller capture a count that
   // includes the current cycle in the same edge it stops counting.
   assign count_next = (&count_q) ? count_q : count_q + 1'b1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else if (clr) begin
         count_q <= '0;
      end else if (en) begin
         count_q <= count_next;
      end
   end

endmodule

// File: rtl/dfx_seq_ctrl.sv
// rtl/dfx_seq_ctrl.sv - bank0 sequencer: walks bank1 slots, issues DMA jobs, writes back status
//
// Purpose: on a start command walks slot table entries 0..end_cnt, reads each
//          slot, issues one DMA job, waits for completion and writes per-slot
//          status (and cycle profile when DFX_SEQ_PROFILE_EN is defined) back
//          to bank1. Abort is honoured at the next slot writeback.
// Ports:
//   clk, reset                       clock, asynchronous active-low reset
//   inp_control/set_control          control word {-, clear, abort, start} + strobe
//   inp_endCnt/set_endCnt            last slot index (inclusive) + strobe
//   status                           {0, aborted, done, busy}
//   cur_cnt                          slot currently processed
//   rd_index, rd_*                   slot table read index and combinational read data
//   job_valid/job_ready, job_*       DMA job handshake and job fields
//   job_done, job_err                DMA completion pulse and error qualifier
//   wb_index, wb_status/wb_set_status, wb_profile/wb_set_profile   bank1 writeback
// Config: DFX_SEQ_PROFILE_EN enables the per-slot cycle profile writeback.

module dfx_seq_ctrl
   import dfx_seq_pkg::*;
#(
   parameter int BANK1_INDEX_WIDTH    = 2,
   parameter int BANK1_SRC_ADDR_WIDTH = 32,
   parameter int BANK1_DST_ADDR_WIDTH = 32,
   parameter int BANK1_SRC_SIZE_WIDTH = 26,
   parameter int BANK1_DST_SIZE_WIDTH = 26,
   parameter int BANK1_STATUS_WIDTH   = 2,
   parameter int BANK1_PROFILE_WIDTH  = 32,
   parameter int BANK0_CONTROL_WIDTH  = 4,
   parameter int BANK0_STATUS_WIDTH   = 4,
   parameter int BANK0_CNT_WIDTH      = BANK1_INDEX_WIDTH
)
(
   input  logic                            clk,
   input  logic                            reset,
   input  logic [BANK0_CONTROL_WIDTH-1:0]  inp_control,
   input  logic                            set_control,
   input  logic [BANK0_CNT_WIDTH-1:0]      inp_endCnt,
   input  logic                            set_endCnt,
   output logic [BANK0_STATUS_WIDTH-1:0]   status,
   output logic [BANK0_CNT_WIDTH-1:0]      cur_cnt,
   output logic [BANK0_CNT_WIDTH-1:0]      rd_index,
   input  logic [BANK1_SRC_ADDR_WIDTH-1:0] rd_src_addr,
   input  logic [BANK1_SRC_SIZE_WIDTH-1:0] rd_src_size,
   input  logic [BANK1_DST_ADDR_WIDTH-1:0] rd_des_addr,
   input  logic [BANK1_DST_SIZE_WIDTH-1:0] rd_des_size,
   output logic                            job_valid,
   input  logic                            job_ready,
   output logic [BANK1_SRC_ADDR_WIDTH-1:0] job_src_addr,
   output logic [BANK1_SRC_SIZE_WIDTH-1:0] job_src_size,
   output logic [BANK1_DST_ADDR_WIDTH-1:0] job_des_addr,
   output logic [BANK1_DST_SIZE_WIDTH-1:0] job_des_size,
   input  logic                            job_done,
   input  logic                            job_err,
   output logic [BANK0_CNT_WIDTH-1:0]      wb_index,
   output logic [BANK1_STATUS_WIDTH-1:0]   wb_status,
   output logic                            wb_set_status,
   output logic [BANK1_PROFILE_WIDTH-1:0]  wb_profile,
   output logic                            wb_set_profile
);

   seq_state_t                 state_q;
   logic [BANK0_CNT_WIDTH-1:0] end_cnt_q;
   logic [BANK0_CNT_WIDTH-1:0] run_end_q;
   logic [BANK0_CNT_WIDTH-1:0] cnt_q;
   logic                       busy_q;
   logic                       done_q;
   logic                       aborted_q;
   logic                       abort_pend_q;

   logic start_cmd;
   logic abort_cmd;
   logic clear_cmd;
   logic ctrl_unused;

   assign start_cmd   = set_control && inp_control[CTRL_START];
   assign abort_cmd   = set_control && inp_control[CTRL_ABORT];
   assign clear_cmd   = set_control && inp_control[CTRL_CLEAR];
   assign ctrl_unused = inp_control[BANK0_CONTROL_WIDTH-1];

   assign status   = {{(BANK0_STATUS_WIDTH-3){1'b0}}, aborted_q, done_q, busy_q};
   assign cur_cnt  = cnt_q;
   // cnt only changes on the way into LOAD, so it is the read index for the whole LOAD cycle.
   assign rd_index = cnt_q;

`ifdef DFX_SEQ_PROFILE_EN
   logic [BANK1_PROFILE_WIDTH-1:0] prof_next;

   dfx_seq_prof_cnt #(
      .WIDTH (BANK1_PROFILE_WIDTH)
   ) u_prof_cnt (
      .clk        (clk),
      .reset      (reset),
      .clr        (state_q == ST_ISSUE && job_ready),
      .en         (state_q == ST_WAIT),
      .count_next (prof_next)
   );
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= ST_IDLE;
         end_cnt_q      <= '0;
         run_end_q      <= '0;
         cnt_q          <= '0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         aborted_q      <= 1'b0;
         abort_pend_q   <= 1'b0;
         job_valid      <= 1'b0;
         job_src_addr   <= '0;
         job_src_size   <= '0;
         job_des_addr   <= '0;
         job_des_size   <= '0;
         wb_index       <= '0;
         wb_status      <= '0;
         wb_set_status  <= 1'b0;
         wb_profile     <= '0;
         wb_set_profile <= 1'b0;
      end else begin
         wb_set_status  <= 1'b0;
         wb_set_profile <= 1'b0;

         if (set_endCnt) begin
            end_cnt_q <= inp_endCnt;
         end

         // WB decides on the live abort strobe itself, so only latch it elsewhere.
         if (abort_cmd && state_q != ST_IDLE && state_q != ST_WB) begin
            abort_pend_q <= 1'b1;
         end

         case (state_q)
            ST_IDLE: begin
               if (start_cmd) begin
                  busy_q       <= 1'b1;
                  done_q       <= 1'b0;
                  aborted_q    <= 1'b0;
                  abort_pend_q <= 1'b0;
                  cnt_q        <= '0;
                  run_end_q    <= end_cnt_q;
                  state_q      <= ST_LOAD;
               end else if (clear_cmd) begin
                  done_q    <= 1'b0;
                  aborted_q <= 1'b0;
               end
            end
            ST_LOAD: begin
               job_src_addr <= rd_src_addr;
               job_src_size <= rd_src_size;
               job_des_addr <= rd_des_addr;
               job_des_size <= rd_des_size;
               job_valid    <= 1'b1;
               state_q      <= ST_ISSUE;
            end
            ST_ISSUE: begin
               if (job_ready) begin
                  job_valid <= 1'b0;
                  state_q   <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (job_done) begin
                  wb_index      <= cnt_q;
                  wb_status     <= job_err ? SLOT_ERR : SLOT_OK;
                  wb_set_status <= 1'b1;
`ifdef DFX_SEQ_PROFILE_EN
                  wb_profile     <= prof_next;
                  wb_set_profile <= 1'b1;
`endif
                  state_q       <= ST_WB;
               end
            end
            ST_WB: begin
               if (cnt_q == run_end_q || abort_pend_q || abort_cmd) begin
                  busy_q       <= 1'b0;
                  done_q       <= 1'b1;
                  aborted_q    <= abort_pend_q || abort_cmd;
                  abort_pend_q <= 1'b0;
                  state_q      <= ST_IDLE;
               end else begin
                  cnt_q   <= cnt_q + 1'b1;
                  state_q <= ST_LOAD;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dfx_seq_ctrl.sv
// tb/tb_dfx_seq_ctrl.sv - scoreboard testbench for dfx_seq_ctrl

module tb_dfx_seq_ctrl;

   localparam int CW = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  inp_control;
   logic        set_control;
   logic [CW-1:0] inp_endCnt;
   logic        set_endCnt;
   logic [3:0]  status;
   logic [CW-1:0] cur_cnt;
   logic [CW-1:0] rd_index;
   logic [31:0] rd_src_addr, rd_des_addr;
   logic [25:0] rd_src_size, rd_des_size;
   logic        job_valid, job_ready;
   logic [31:0] job_src_addr, job_des_addr;
   logic [25:0] job_src_size, job_des_size;
   logic        job_done, job_err;
   logic [CW-1:0] wb_index;
   logic [1:0]  wb_status;
   logic        wb_set_status;
   logic [31:0] wb_profile;
   logic        wb_set_profile;

   dfx_seq_ctrl dut (
      .clk(clk), .reset(reset),
      .inp_control(inp_control), .set_control(set_control),
      .inp_endCnt(inp_endCnt), .set_endCnt(set_endCnt),
      .status(status), .cur_cnt(cur_cnt), .rd_index(rd_index),
      .rd_src_addr(rd_src_addr), .rd_src_size(rd_src_size),
      .rd_des_addr(rd_des_addr), .rd_des_size(rd_des_size),
      .job_valid(job_valid), .job_ready(job_ready),
      .job_src_addr(job_src_addr), .job_src_size(job_src_size),
      .job_des_addr(job_des_addr), .job_des_size(job_des_size),
      .job_done(job_done), .job_err(job_err),
      .wb_index(wb_index), .wb_status(wb_status), .wb_set_status(wb_set_status),
      .wb_profile(wb_profile), .wb_set_profile(wb_set_profile)
   );

   always #5 clk = ~clk;

   typedef struct { int idx; logic [31:0] sa; logic [25:0] ss; logic [31:0] da; logic [25:0] ds; } job_t;
   typedef struct { int idx; logic [1:0] st; int prof; } wb_t;

   job_t job_q[$];
   wb_t  wb_q[$];

   logic [31:0] tbl_sa[4], tbl_da[4];
   logic [25:0] tbl_ss[4], tbl_ds[4];

   always_comb begin
      rd_src_addr = tbl_sa[rd_index];
      rd_src_size = tbl_ss[rd_index];
      rd_des_addr = tbl_da[rd_index];
      rd_des_size = tbl_ds[rd_index];
   end

   int total = 0;
   int bad = 0;
   int acc_count = 0;
   int cur_job_idx = 0;
   int hold_ready = 0;
   int min_d = 1;
   bit force_err = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      total++;
      bad++;
      $display("FAIL %s: got timeout/unexpected expected event", name);
   endtask

   // DMA engine stub: random accept latency, random completion delay d,
   // occasional stray done pulses while no job is outstanding.
   initial begin
      int  cnt;
      int  d;
      bit  e;
      cnt = 0; d = 0;
      job_ready = 1'b0; job_done = 1'b0; job_err = 1'b0;
      forever begin
         @(negedge clk);
         job_ready = 1'b0; job_done = 1'b0; job_err = 1'b0;
         if (!reset) begin
            cnt = 0;
         end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               e = force_err || ($urandom_range(0, 3) == 0);
               job_done = 1'b1;
               job_err  = e;
               wb_q.push_back('{cur_job_idx, e ? 2'b11 : 2'b10, d});
            end
         end else if (job_valid && hold_ready > 0) begin
            hold_ready--;
         end else if (job_valid && $urandom_range(0, 2) != 0) begin
            job_ready = 1'b1;
            d = int'($urandom_range(min_d, 6));
            cnt = d;
         end else if ($urandom_range(0, 9) == 0) begin
            job_done = 1'b1;
            job_err  = 1'($urandom_range(0, 1));
         end
      end
   end

   // Monitor: checks held job fields, pops the scoreboard on accept and writeback.
   initial begin
      bit          pv;
      logic [31:0] p_sa, p_da;
      logic [25:0] p_ss, p_ds;
      job_t        j;
      wb_t         w;
      pv = 1'b0;
      forever begin
         @(negedge clk);
         #1;
         if (!reset) begin
            pv = 1'b0;
            continue;
         end
         if (pv) begin
            check("hold_valid", 64'(job_valid), 64'(1'b1));
            check("hold_src_addr", 64'(job_src_addr), 64'(p_sa));
            check("hold_src_size", 64'(job_src_size), 64'(p_ss));
            check("hold_des_addr", 64'(job_des_addr), 64'(p_da));
            check("hold_des_size", 64'(job_des_size), 64'(p_ds));
         end
         pv = job_valid && !job_ready;
         p_sa = job_src_addr; p_ss = job_src_size; p_da = job_des_addr; p_ds = job_des_size;
         if (job_valid && job_ready) begin
            if (job_q.size() == 0) begin
               fail_now("unexpected_job");
            end else begin
               j = job_q.pop_front();
               check("job_src_addr", 64'(job_src_addr), 64'(j.sa));
               check("job_src_size", 64'(job_src_size), 64'(j.ss));
               check("job_des_addr", 64'(job_des_addr), 64'(j.da));
               check("job_des_size", 64'(job_des_size), 64'(j.ds));
               cur_job_idx = j.idx;
            end
            acc_count++;
         end
         if (wb_set_status) begin
            if (wb_q.size() == 0) begin
               fail_now("unexpected_wb");
            end else begin
               w = wb_q.pop_front();
               check("wb_index", 64'(wb_index), 64'(w.idx));
               check("wb_status", 64'(wb_status), 64'(w.st));
`ifdef DFX_SEQ_PROFILE_EN
               check("wb_set_profile", 64'(wb_set_profile), 64'(1'b1));
               check("wb_profile", 64'(wb_profile), 64'(w.prof));
`else
               check("wb_set_profile", 64'(wb_set_profile), 64'(1'b0));
               check("wb_profile", 64'(wb_profile), 64'(0));
`endif
            end
         end
      end
   end

   task automatic load_table();
      for (int i = 0; i < 4; i++) begin
         tbl_sa[i] = $urandom;
         tbl_ss[i] = 26'($urandom);
         tbl_da[i] = $urandom;
         tbl_ds[i] = 26'($urandom);
      end
   endtask

   task automatic start_run(input int e, input int last);
      for (int i = 0; i <= last; i++)
         job_q.push_back('{i, tbl_sa[i], tbl_ss[i], tbl_da[i], tbl_ds[i]});
      @(negedge clk);
      inp_endCnt = CW'(e); set_endCnt = 1'b1;
      @(negedge clk);
      set_endCnt = 1'b0; inp_control = 4'b0001; set_control = 1'b1;
      @(negedge clk);
      set_control = 1'b0; inp_control = 4'b0000;
   endtask

   task automatic ctrl_pulse(input logic [3:0] v);
      @(negedge clk);
      inp_control = v; set_control = 1'b1;
      @(negedge clk);
      set_control = 1'b0; inp_control = 4'b0000;
   endtask

   task automatic wait_acc(input int target);
      int n;
      n = 0;
      while (acc_count < target && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (n >= 500) fail_now("accept_timeout");
   endtask

   task automatic finish_run(input string name, input logic [3:0] exp_status);
      int n;
      n = 0;
      while (status[0] && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 3000) fail_now("busy_timeout");
      #1;
      check(name, 64'(status), 64'(exp_status));
      check("jobs_left", 64'(job_q.size()), 64'(0));
      check("wbs_left", 64'(wb_q.size()), 64'(0));
   endtask

   initial begin
      int base;
      int e;
      int k;
      reset = 1'b0;
      inp_control = 4'b0; set_control = 1'b0; inp_endCnt = '0; set_endCnt = 1'b0;
      load_table();
      repeat (3) @(negedge clk);
      #1;
      check("rst_status", 64'(status), 64'(0));
      check("rst_cur_cnt", 64'(cur_cnt), 64'(0));
      check("rst_rd_index", 64'(rd_index), 64'(0));
      check("rst_job_valid", 64'(job_valid), 64'(0));
      check("rst_job_src_addr", 64'(job_src_addr), 64'(0));
      check("rst_job_des_size", 64'(job_des_size), 64'(0));
      check("rst_wb_set_status", 64'(wb_set_status), 64'(0));
      check("rst_wb_status", 64'(wb_status), 64'(0));
      check("rst_wb_profile", 64'(wb_profile), 64'(0));
      @(negedge clk);
      reset = 1'b1;

      // three slots, start-to-valid latency
      start_run(2, 2);
      #1;
      check("load_status_busy", 64'(status), 64'(4'b0001));
      check("load_job_valid", 64'(job_valid), 64'(0));
      check("load_rd_index", 64'(rd_index), 64'(0));
      @(negedge clk);
      #1;
      check("issue_job_valid", 64'(job_valid), 64'(1));
      check("issue_src_addr", 64'(job_src_addr), 64'(tbl_sa[0]));
      finish_run("run3_status", 4'b0010);

      // ready held low for four ISSUE cycles
      load_table();
      hold_ready = 4;
      start_run(0, 0);
      finish_run("hold_status", 4'b0010);

      // error completion on the last slot
      force_err = 1'b1;
      start_run(1, 1);
      finish_run("err_status", 4'b0010);
      force_err = 1'b0;

      // abort during slot 0 of a four-slot run
      base = acc_count;
      start_run(3, 0);
      wait_acc(base + 1);
      inp_control = 4'b0010; set_control = 1'b1;
      @(negedge clk);
      set_control = 1'b0; inp_control = 4'b0000;
      finish_run("abort_status", 4'b0110);

      // clear in IDLE, abort in IDLE ignored
      ctrl_pulse(4'b0100);
      #1;
      check("clear_status", 64'(status), 64'(0));
      ctrl_pulse(4'b0010);
      #1;
      check("idle_abort_status", 64'(status), 64'(0));
      start_run(0, 0);
      finish_run("after_idle_abort", 4'b0010);

      // randomized runs
      for (int r = 0; r < 12; r++) begin
         load_table();
         e = int'($urandom_range(0, 3));
         base = acc_count;
         if ($urandom_range(0, 1) == 1) begin
            k = int'($urandom_range(0, e));
            start_run(e, k);
            wait_acc(base + k + 1);
            inp_control = 4'b0010; set_control = 1'b1;
            @(negedge clk);
            set_control = 1'b0; inp_control = 4'b0000;
            finish_run("rand_abort_status", 4'b0110);
         end else begin
            start_run(e, e);
            wait_acc(base + 1);
            // start+clear and a new endCnt while busy must not disturb the run
            inp_control = 4'b0101; set_control = 1'b1;
            inp_endCnt = ~CW'(e); set_endCnt = 1'b1;
            @(negedge clk);
            set_control = 1'b0; inp_control = 4'b0000; set_endCnt = 1'b0;
            finish_run("rand_status", 4'b0010);
         end
      end

      // reset while waiting for completion
      min_d = 4;
      base = acc_count;
      start_run(0, 0);
      wait_acc(base + 1);
      reset = 1'b0;
      #1;
      check("midrst_status", 64'(status), 64'(0));
      check("midrst_cur_cnt", 64'(cur_cnt), 64'(0));
      check("midrst_job_valid", 64'(job_valid), 64'(0));
      check("midrst_job_src_addr", 64'(job_src_addr), 64'(0));
      check("midrst_wb_set_status", 64'(wb_set_status), 64'(0));
      repeat (2) @(negedge clk);
      reset = 1'b1;
      min_d = 1;
      repeat (12) @(negedge clk);
      #1;
      check("postrst_status", 64'(status), 64'(0));
      check("postrst_wbs_left", 64'(wb_q.size()), 64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
